fft_alu_pipe: RTL
=================

Name: fft_alu_pipe

Overview:
- Parametrised, pipelined successor of the FFT datapath ALU.
- Runs the same operation set (add, sub, conditional negate, add-C, multiply) at generic width and with fixed-point multiply (Q-format rounding).
- Adds a per-result overflow flag and a valid/ready handshake on input and output, so the FFT control FSM can stall the datapath.
- Sits between the butterfly operand mux and the result write-back of the radix-2 FFT core.

Parameters:
- DATA_W, 16, operand and result width (two's complement, >= 4)
- FRAC_W, 15, fractional bits for MULT rescaling (1 <= FRAC_W < DATA_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid_i  in  1  operand set valid
- in_ready_o  out  1  ALU accepts operands this cycle
- op_a_i  in  DATA_W  signed operand A
- op_b_i  in  DATA_W  signed operand B
- op_c_i  in  DATA_W  signed operand C
- alu_mode_i  in  4  operation select (ALUMODE_* encodings)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- res_o  out  DATA_W  signed result
- ovf_o  out  1  result exceeded DATA_W signed range

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high. On reset, both stage valids, out_valid_o, res_o and ovf_o are 0; any in-flight operations are discarded.
- Handshake:
  - adv = !out_valid_o || out_ready_i; in_ready_o = adv (combinational).
  - Input transfer when in_valid_i && in_ready_o; output transfer when out_valid_o && out_ready_i.
  - When adv=0 both stages hold contents and valids; res_o and ovf_o stay stable while out_valid_o=1 and out_ready_i=0.
  - Pipeline bubbles propagate as valid=0; no bubble collapsing is required.
- Latency: 2 cycles from input transfer to out_valid_o, when not stalled. Throughput is 1 per cycle with out_ready_i held high.
- Stage 1 (on adv) registers s1_valid = in_valid_i and a full-precision intermediate of 2*DATA_W bits:
  - IDLE (0): 0.
  - A_ADD_B (1): a+b, sign-extended.
  - A_SUB_B (2): a-b.
  - A_SIGN_B (3): -a if b != 0, else a.
  - A_ADDSUB_C (4): a+c.
  - A_MULT_B (5): a*b, full signed product.
  - Codes 6-15: 0, with an illegal flag carried to stage 2.
- Stage 2 (on adv) registers out_valid_o = s1_valid.
  - MULT: add 2^(FRAC_W-1) (round half up), then arithmetic shift right by FRAC_W.
  - Other modes: no shift.
  - Range check against [-2^(DATA_W-1), 2^(DATA_W-1)-1]: ovf_o=1 if outside, or if the mode code was illegal.
  - res_o = low DATA_W bits of the result (wrap), or saturated per the Optional Feature. Illegal codes give res_o=0.
- Boundary cases:
  - SIGN with a = -2^(DATA_W-1) and b != 0 overflows (ovf_o=1).
  - MULT of (-1.0)*(-1.0) overflows.
  - Simultaneous output transfer and new input: both occur in the same cycle.
  - Reset asserted mid-stall clears everything; in_ready_o=1 in the cycle after reset.

Optional Feature:
- Macro FFT_ALU_SAT_EN.
- Defined: on overflow, res_o clamps to 2^(DATA_W-1)-1 (positive) or -2^(DATA_W-1) (negative); ovf_o is still asserted.
- Undefined: res_o wraps (two's-complement truncation); ovf_o is still asserted.
- Illegal mode codes give res_o=0 in both builds.

Test Plan:
- Reset then idle: hold rst 2 cycles, then drive in_valid_i=0 -> out_valid_o=0, res_o=0, ovf_o=0, in_ready_o=1.
- MULT Q1.15 (DATA_W=16, FRAC_W=15), out_ready_i=1:
  - a=0x4000, b=0x4000 -> res_o=0x2000, ovf_o=0, out_valid_o 2 cycles after transfer.
  - a=0x8000, b=0x8000 -> ovf_o=1; res_o=0x8000 with wrap, 0x7FFF with FFT_ALU_SAT_EN.
- ADD overflow: a=0x7FFF, b=0x0001 -> ovf_o=1; res_o=0x8000 with wrap, 0x7FFF with sat. SUB a=0x0003, b=0x0005 -> 0xFFFE, ovf_o=0.
- Back-to-back with backpressure: issue ADD(1,2), SUB(9,4), SIGN(7,1) on consecutive cycles; hold out_ready_i=0 for 3 cycles after the first result appears.
  - Required: res_o holds 3, in_ready_o=0.
  - On release, results 3, 5, 0xFFF9 are delivered in order, with no loss or duplication.
- Reset mid-operation: two ops in flight and stalled, assert rst for 1 cycle -> out_valid_o=0 next cycle, and no stale result ever appears.
- Illegal mode 0xA with a=5 -> res_o=0, ovf_o=1, out_valid_o=1.

Source files
------------

// File: rtl/fft_alu_pipe.sv
// Two-stage pipelined FFT datapath ALU with valid/ready handshake and overflow flag.
// Define FFT_ALU_SAT_EN to saturate overflowing results instead of wrapping them.
module fft_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic [DATA_W-1:0] op_c_i,
    input  logic [3:0]        alu_mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] res_o,
    output logic              ovf_o
);
    localparam int PW = 2 * DATA_W;

    localparam logic [3:0] ALUMODE_IDLE       = 4'd0;
    localparam logic [3:0] ALUMODE_A_ADD_B    = 4'd1;
    localparam logic [3:0] ALUMODE_A_SUB_B    = 4'd2;
    localparam logic [3:0] ALUMODE_A_SIGN_B   = 4'd3;
    localparam logic [3:0] ALUMODE_A_ADDSUB_C = 4'd4;
    localparam logic [3:0] ALUMODE_A_MULT_B   = 4'd5;

    localparam logic signed [PW-1:0]     RND_K   = PW'(1) << (FRAC_W - 1);
    localparam logic        [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic        [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic adv;
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    // Stage 1: full-precision intermediate
    logic signed [PW-1:0] a_x, b_x, c_x;
    logic signed [PW-1:0] s1_val_d, s1_val_q;
    logic                 s1_mult_d, s1_mult_q;
    logic                 s1_ill_d, s1_ill_q;
    logic                 s1_valid_q;

    assign a_x = {{DATA_W{op_a_i[DATA_W-1]}}, op_a_i};
    assign b_x = {{DATA_W{op_b_i[DATA_W-1]}}, op_b_i};
    assign c_x = {{DATA_W{op_c_i[DATA_W-1]}}, op_c_i};

    always_comb begin
        s1_val_d  = '0;
        s1_mult_d = 1'b0;
        s1_ill_d  = 1'b0;
        case (alu_mode_i)
            ALUMODE_IDLE:       s1_val_d = '0;
            ALUMODE_A_ADD_B:    s1_val_d = a_x + b_x;
            ALUMODE_A_SUB_B:    s1_val_d = a_x - b_x;
            ALUMODE_A_SIGN_B:   s1_val_d = (op_b_i != '0) ? -a_x : a_x;
            ALUMODE_A_ADDSUB_C: s1_val_d = a_x + c_x;
            ALUMODE_A_MULT_B: begin
                // Product of two DATA_W values always fits in PW bits
                s1_val_d  = a_x * b_x;
                s1_mult_d = 1'b1;
            end
            default:            s1_ill_d = 1'b1;
        endcase
    end

    // Stage 2: Q-format rescale, range check, wrap or saturate
    logic signed [PW-1:0]     rnd, scl;
    logic                     in_range;
    logic [DATA_W-1:0]        res_d, res_q;
    logic                     ovf_d, ovf_q;
    logic                     out_valid_q;

    always_comb begin
        rnd      = s1_val_q + RND_K;
        scl      = s1_mult_q ? (rnd >>> FRAC_W) : s1_val_q;
        in_range = (scl[PW-1:DATA_W-1] == '0) || (scl[PW-1:DATA_W-1] == '1);
        ovf_d    = s1_ill_q || !in_range;
        res_d    = scl[DATA_W-1:0];
        if (s1_ill_q) begin
            res_d = '0;
        end else if (!in_range) begin
`ifdef FFT_ALU_SAT_EN
            res_d = scl[PW-1] ? RES_MIN : RES_MAX;
`else
            res_d = scl[DATA_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_val_q    <= '0;
            s1_mult_q   <= 1'b0;
            s1_ill_q    <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= in_valid_i;
            s1_val_q    <= s1_val_d;
            s1_mult_q   <= s1_mult_d;
            s1_ill_q    <= s1_ill_d;
            out_valid_q <= s1_valid_q;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign res_o       = res_q;
    assign ovf_o       = ovf_q;
endmodule
